synth_wave_gen: RTL and testbench
=================================

Name: synth_wave_gen

Overview:
Audio-rate waveform synthesizer sitting directly upstream of the I2S transmit controller. It drives that controller's left/right sample inputs as a mono sample.
- Phase-accumulator oscillator producing square, saw or triangle samples, amplitude-scaled.
- Advances exactly one sample per audio frame, paced by the controller's LRCLK output, which is in the same clock domain.
- D_O is held stable between frames, so the serializer may sample it at any time.

Parameters:
DATA_W, 24, sample width (signed two's complement).
PHASE_W, 32, phase accumulator width; must satisfy PHASE_W >= DATA_W+1.

Ports:
CLK_I  in  1  system clock (same 12.288 MHz clock as the I2S controller).
RST_I  in  1  asynchronous active-low reset.
EN_I  in  1  1 = frame edges advance the oscillator; 0 = frame edges ignored.
LRCLK_I  in  1  frame clock from I2S controller, synchronous to CLK_I.
FTW_I  in  PHASE_W  frequency tuning word added to the phase once per frame.
WAVE_SEL_I  in  2  0 square, 1 saw, 2 triangle, 3 silence.
AMP_I  in  9  unsigned gain, 256 = unity; values >256 saturate to 256.
PHASE_RST_I  in  1  synchronous phase-accumulator clear.
D_O  out  DATA_W  signed sample to I2S D_L_I/D_R_I.
STB_O  out  1  one-cycle pulse in the cycle D_O takes a new value.

Behaviour:
- Reset (RST_I=0, async):
  - phase=0, D_O=0, STB_O=0, all pipeline valids=0.
  - Registered LRCLK (lrclk_q)=0, so no spurious edge after release.
- Frame edge, cycle E: LRCLK_I==0 && lrclk_q==1 && EN_I==1. lrclk_q <= LRCLK_I every cycle.
- Pipeline, fixed latency 3:
  - At E: FTW_I, WAVE_SEL_I, AMP_I captured. Inputs changing at any other cycle have no effect on the sample in flight.
  - E+1: phase <= phase + FTW, modulo 2^PHASE_W (wrap silent).
  - E+2: raw waveform computed from the new phase.
  - E+3: D_O <= scaled value; STB_O=1 for exactly this cycle.
- PHASE_RST_I:
  - At a non-edge cycle: phase <= 0 next cycle.
  - Coincident with E: phase <= 0 + FTW, i.e. clear then add.
- Waveform definitions. M = phase[PHASE_W-1], p = phase[PHASE_W-1 -: DATA_W], h = 2^(DATA_W-1).
  - Square: M=0 -> +(h-1); M=1 -> -(h-1).
  - Saw: p with MSB inverted (ramps -h .. h-1).
  - Triangle: u = phase[PHASE_W-2 -: DATA_W]; if M=1, u = ~u; raw = u with MSB inverted.
  - Silence: 0.
- Scaling:
  - D_O = (raw * g) >>> 8, where g = min(AMP_I, 256).
  - Full-precision signed product; arithmetic shift (floor); truncate to DATA_W.
  - g=0 -> 0.
- EN_I=0:
  - Edges are not detected; phase, D_O hold; no STB_O.
  - A sample already in the pipeline still completes and strobes.
- Back-to-back edges: LRCLK period (256 cycles) always exceeds latency. A second edge arriving while the pipeline is busy is still accepted, since the pipeline is fully pipelined.
- Reset mid-pipeline: in-flight sample discarded; no STB_O after reset release until a new edge.

Test Plan:
1. Hold RST_I=0 while toggling LRCLK_I -> D_O=0, STB_O=0 throughout. Release mid-high LRCLK -> first STB_O exactly 3 cycles after the first falling edge.
2. Saw, FTW=0x0100_0000, AMP_I=256:
   - Frame 1 -> D_O=0x810000, STB_O at E+3.
   - Frame 128 -> 0x000000.
   - Frame 256 -> 0x800000 (wrap).
3. Square, FTW=0x4000_0000, AMP_I=128 -> D_O sequence 0x3FFFFF, 0xC00000, 0xC00000, 0x3FFFFF.
4. Triangle, FTW=0x4000_0000, AMP_I=256 -> D_O sequence 0x000000, 0x7FFFFF, 0xFFFFFF, 0x800000, repeating.
5. Gating and capture timing:
   - EN_I=0 for 3 edges -> no STB_O, D_O holds.
   - Re-enable -> the next sample continues from the held phase.
   - WAVE_SEL_I changed at E+1 -> the current sample is unaffected; the change applies at the next edge.
6. Clear and saturation: PHASE_RST_I coincident with E, saw, FTW=0x0100_0000, AMP_I=0x1FF -> D_O=0x810000 (saturated = unity).
7. Reset mid-pipeline: RST_I pulsed low at E+1 -> no STB_O, D_O=0.

Source files
------------

// File: rtl/synth_wave_gen.sv
`timescale 1ns/1ps
// Phase-accumulator waveform synthesizer feeding the I2S transmitter as a mono sample.
// One sample per LRCLK falling edge, fixed 3-cycle latency, output held between frames.
module synth_wave_gen #(
  parameter int DATA_W  = 24,
  parameter int PHASE_W = 32
) (
  input  logic               CLK_I,
  input  logic               RST_I,
  input  logic               EN_I,
  input  logic               LRCLK_I,
  input  logic [PHASE_W-1:0] FTW_I,
  input  logic [1:0]         WAVE_SEL_I,
  input  logic [8:0]         AMP_I,
  input  logic               PHASE_RST_I,
  output logic [DATA_W-1:0]  D_O,
  output logic               STB_O
);

  localparam int PROD_W = DATA_W + 10;
  localparam logic [DATA_W-1:0] SQ_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SQ_NEG = {1'b1, {(DATA_W-2){1'b0}}, 1'b1};
  localparam logic [8:0]        UNITY  = 9'd256;

  logic                      lrclk_r;
  logic                      frame_edge_s;
  logic [PHASE_W-1:0]        phase_r;
  logic [1:0]                sel_r;
  logic [8:0]                gain_r;
  logic                      v1_r;
  logic signed [DATA_W-1:0]  raw_r;
  logic [8:0]                gain2_r;
  logic                      v2_r;
  logic [8:0]                gain_s;
  logic [DATA_W-1:0]         p_s;
  logic [DATA_W-1:0]         u_s;
  logic [DATA_W-1:0]         tri_s;
  logic [DATA_W-1:0]         raw_s;
  logic signed [PROD_W-1:0]  prod_s;
  logic [DATA_W-1:0]         scaled_s;

  assign frame_edge_s = ~LRCLK_I & lrclk_r & EN_I;
  assign gain_s       = (AMP_I > UNITY) ? UNITY : AMP_I;
  assign p_s          = phase_r[PHASE_W-1 -: DATA_W];
  assign u_s          = phase_r[PHASE_W-2 -: DATA_W] ^ {DATA_W{phase_r[PHASE_W-1]}};
  assign tri_s        = {~u_s[DATA_W-1], u_s[DATA_W-2:0]};

  // Raw waveform from the freshly advanced phase
  always_comb begin
    raw_s = {DATA_W{1'b0}};
    case (sel_r)
      2'd0:    raw_s = phase_r[PHASE_W-1] ? SQ_NEG : SQ_POS;
      2'd1:    raw_s = {~p_s[DATA_W-1], p_s[DATA_W-2:0]};
      2'd2:    raw_s = tri_s;
      default: raw_s = {DATA_W{1'b0}};
    endcase
  end

  // Full-precision signed product, floor shift by 8 (256 = unity gain)
  assign prod_s   = PROD_W'(raw_r) * $signed(PROD_W'({1'b0, gain2_r}));
  assign scaled_s = DATA_W'(prod_s >>> 4'd8);

  // Frame-edge detection, phase accumulation and capture of per-sample controls
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      lrclk_r <= 1'b0;
      phase_r <= {PHASE_W{1'b0}};
      sel_r   <= 2'd0;
      gain_r  <= 9'd0;
      v1_r    <= 1'b0;
    end else begin
      lrclk_r <= LRCLK_I;
      v1_r    <= frame_edge_s;
      if (frame_edge_s) begin
        phase_r <= (PHASE_RST_I ? {PHASE_W{1'b0}} : phase_r) + FTW_I;
        sel_r   <= WAVE_SEL_I;
        gain_r  <= gain_s;
      end else if (PHASE_RST_I) begin
        phase_r <= {PHASE_W{1'b0}};
      end else begin
        phase_r <= phase_r;
      end
    end
  end

  // Waveform stage; gain travels alongside so overlapping samples stay independent
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      raw_r   <= {DATA_W{1'b0}};
      gain2_r <= 9'd0;
      v2_r    <= 1'b0;
    end else begin
      v2_r <= v1_r;
      if (v1_r) begin
        raw_r   <= raw_s;
        gain2_r <= gain_r;
      end else begin
        raw_r   <= raw_r;
        gain2_r <= gain2_r;
      end
    end
  end

  // Output register: sample held between frames, strobe marks each update
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      D_O   <= {DATA_W{1'b0}};
      STB_O <= 1'b0;
    end else begin
      STB_O <= v2_r;
      if (v2_r) begin
        D_O <= scaled_s;
      end else begin
        D_O <= D_O;
      end
    end
  end

endmodule

// File: tb/tb_synth_wave_gen.sv
`timescale 1ns/1ps
// Directed bench for synth_wave_gen: a reference model pushes expected samples at each
// frame edge; a monitor pops them on STB_O and checks both value and latency.
module tb_synth_wave_gen;

  localparam int     DATA_W = 24;
  localparam int     PHASE_W = 32;
  localparam int     HALF = 8;
  localparam longint HSCALE = 64'sd8388608;
  localparam longint FSCALE = 64'sd16777216;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               en = 1'b0;
  logic               lrclk = 1'b0;
  logic               phase_rst = 1'b0;
  logic [PHASE_W-1:0] ftw = 32'h0;
  logic [1:0]         wave_sel = 2'd0;
  logic [8:0]         amp = 9'd0;
  logic [DATA_W-1:0]  d_o;
  logic               stb_o;

  int                 errors = 0;
  int                 checks = 0;
  int                 cyc = 0;
  logic [PHASE_W-1:0] mdl_phase = 32'h0;
  logic [DATA_W-1:0]  exp_q[$];
  int                 due_q[$];

  synth_wave_gen #(.DATA_W(DATA_W), .PHASE_W(PHASE_W)) dut (
    .CLK_I(clk), .RST_I(rst_n), .EN_I(en), .LRCLK_I(lrclk), .FTW_I(ftw),
    .WAVE_SEL_I(wave_sel), .AMP_I(amp), .PHASE_RST_I(phase_rst),
    .D_O(d_o), .STB_O(stb_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] model(input logic [31:0] ph, input logic [1:0] sel,
                                               input logic [8:0] a);
    longint raw, g, prod, t;
    case (sel)
      2'd0: raw = ph[31] ? -(HSCALE - 1) : (HSCALE - 1);
      2'd1: raw = longint'(ph[31:8]) - HSCALE;
      2'd2: begin
        t   = longint'(ph[30:7]);
        raw = ph[31] ? (FSCALE - 1 - t) - HSCALE : t - HSCALE;
      end
      default: raw = 0;
    endcase
    g    = (a > 9'd256) ? 256 : longint'(a);
    prod = (raw * g) >>> 8;
    return prod[DATA_W-1:0];
  endfunction

  // One LRCLK frame; optional WAVE_SEL change one cycle after the edge, optional clear at the edge
  task automatic frame(input bit late_chg, input logic [1:0] late_sel, input bit prst);
    @(negedge clk); lrclk = 1'b1;
    repeat (HALF - 1) @(negedge clk);
    @(negedge clk); lrclk = 1'b0; phase_rst = prst;
    if (prst) mdl_phase = 32'h0;
    if (en) begin
      mdl_phase = mdl_phase + ftw;
      exp_q.push_back(model(mdl_phase, wave_sel, amp));
      due_q.push_back(cyc + 3);
    end
    @(posedge clk); #1;
    phase_rst = 1'b0;
    if (late_chg) wave_sel = late_sel;
    repeat (HALF - 1) @(negedge clk);
  endtask

  always @(negedge clk) begin : monitor
    logic [DATA_W-1:0] e;
    int d;
    if (stb_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_stb", {31'd0, stb_o}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        d = due_q.pop_front();
        check("sample", {8'd0, d_o}, {8'd0, e});
        check("latency", cyc, d);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DATA_W-1:0] tri_exp [4];
    tri_exp[0] = 24'h000000; tri_exp[1] = 24'h7FFFFF;
    tri_exp[2] = 24'hFFFFFF; tri_exp[3] = 24'h800000;

    // 1: reset holds everything quiet even while LRCLK toggles
    for (int i = 0; i < 6; i++) begin
      repeat (3) @(negedge clk);
      lrclk = ~lrclk;
      check("rst_d", {8'd0, d_o}, 32'd0);
      check("rst_stb", {31'd0, stb_o}, 32'd0);
    end
    en = 1'b1; wave_sel = 2'd1; ftw = 32'h0100_0000; amp = 9'd256;
    @(negedge clk); lrclk = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 2: saw ramp, first frame right after release, then wrap at 256
    frame(1'b0, 2'd0, 1'b0);
    check("saw_f1", {8'd0, d_o}, 32'h0081_0000);
    for (int i = 2; i <= 256; i++) begin
      frame(1'b0, 2'd0, 1'b0);
      if (i == 128) check("saw_f128", {8'd0, d_o}, 32'h0000_0000);
    end
    check("saw_f256", {8'd0, d_o}, 32'h0080_0000);

    // 3: half-gain square
    wave_sel = 2'd0; ftw = 32'h4000_0000; amp = 9'd128;
    frame(1'b0, 2'd0, 1'b0); check("sq_1", {8'd0, d_o}, 32'h003F_FFFF);
    frame(1'b0, 2'd0, 1'b0); check("sq_2", {8'd0, d_o}, 32'h00C0_0000);
    frame(1'b0, 2'd0, 1'b0); check("sq_3", {8'd0, d_o}, 32'h00C0_0000);
    frame(1'b0, 2'd0, 1'b0); check("sq_4", {8'd0, d_o}, 32'h003F_FFFF);

    // 4: unity triangle, two periods
    wave_sel = 2'd2; amp = 9'd256;
    for (int i = 0; i < 8; i++) begin
      frame(1'b0, 2'd0, 1'b0);
      check("tri", {8'd0, d_o}, {8'd0, tri_exp[i % 4]});
    end

    // 5: gating holds phase and output; late WAVE_SEL change waits for the next edge
    wave_sel = 2'd1; ftw = 32'h0100_0000;
    repeat (3) frame(1'b0, 2'd0, 1'b0);
    check("pre_gate", {8'd0, d_o}, 32'h0083_0000);
    en = 1'b0;
    repeat (3) frame(1'b0, 2'd0, 1'b0);
    check("gate_hold", {8'd0, d_o}, 32'h0083_0000);
    en = 1'b1;
    frame(1'b0, 2'd0, 1'b0);
    check("gate_resume", {8'd0, d_o}, 32'h0084_0000);
    frame(1'b1, 2'd0, 1'b0);
    check("late_sel_cur", {8'd0, d_o}, 32'h0085_0000);
    frame(1'b0, 2'd0, 1'b0);
    check("late_sel_next", {8'd0, d_o}, 32'h007F_FFFF);

    // Clear between edges restarts the ramp from zero
    wave_sel = 2'd1;
    @(negedge clk); phase_rst = 1'b1; mdl_phase = 32'h0;
    @(negedge clk); phase_rst = 1'b0;
    frame(1'b0, 2'd0, 1'b0);
    check("clr_idle", {8'd0, d_o}, 32'h0081_0000);

    // 6: clear coincident with the edge, over-range gain saturates to unity
    repeat (2) frame(1'b0, 2'd0, 1'b0);
    amp = 9'h1FF;
    frame(1'b0, 2'd0, 1'b1);
    check("clr_edge_sat", {8'd0, d_o}, 32'h0081_0000);

    // 7: reset one cycle after an edge discards the in-flight sample
    @(negedge clk); lrclk = 1'b1;
    repeat (HALF - 1) @(negedge clk);
    @(negedge clk); lrclk = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete(); due_q.delete(); mdl_phase = 32'h0;
    #1;
    check("midrst_d", {8'd0, d_o}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_stb", {31'd0, stb_o}, 32'd0);
      check("post_rst_d", {8'd0, d_o}, 32'd0);
    end
    amp = 9'd256;
    frame(1'b0, 2'd0, 1'b0);
    check("post_rst_frame", {8'd0, d_o}, 32'h0081_0000);

    repeat (10) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
